// File: rtl/ps2_key_receiver.sv
// PS/2 Set 2 keyboard receiver: synchronizes the raw pins, deframes 11-bit
// frames into bytes, tracks E0/F0 prefixes and drives a clean jump_key level.
`timescale 1ns/1ps
module ps2_key_receiver #(
  parameter logic [7:0] JUMP_SCANCODE  = 8'h29,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       proc_clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       jump_key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [3:0]      bit_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            ext_pending;
  logic            brk_pending;
  logic [7:0]      shift_reg;
  logic            parity_bit;

  logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic ps2_data_p0, ps2_data_p1;
  logic fall;
  logic data_bit;
  logic timeout_hit;

  // Odd parity over data plus parity bit, and a high stop bit, make a good frame
  function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic stop);
    return (^{d, p}) & stop;
  endfunction

  // Two-flop synchronizers (idle high) plus one extra ps2_clk stage for edge detection
  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  // ---- stage boundary: synchronized pins -> frame FSM ----
  assign fall        = ps2_clk_p2 & ~ps2_clk_p1;
  assign data_bit    = ps2_data_p1;
  assign timeout_hit = (state != IDLE) && (to_cnt == TO_LAST);

  // Frame FSM, watchdog, prefix decode and registered outputs
  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      to_cnt      <= '0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      jump_key    <= 1'b0;
      scan_code   <= 8'h00;
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (timeout_hit) begin
        // Abandoned partial frame; a coincident fall is deliberately dropped
        state       <= IDLE;
        to_cnt      <= '0;
        frame_error <= 1'b1;
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else begin
        if (fall || state == IDLE) to_cnt <= '0;
        else                       to_cnt <= to_cnt + 1'b1;

        unique case (state)
          IDLE: begin
            if (fall) begin
              if (!data_bit) begin
                state   <= DATA;
                bit_cnt <= 4'd0;
              end else begin
                frame_error <= 1'b1;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
              end
            end
          end
          DATA: begin
            if (fall) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) state <= PARITY;
            end
          end
          PARITY: begin
            if (fall) state <= STOP;
          end
          STOP: begin
            if (fall) begin
              state <= IDLE;
              if (frame_ok(shift_reg, parity_bit, data_bit)) begin
                scan_code  <= shift_reg;
                scan_valid <= 1'b1;
                if (shift_reg == 8'hE0) begin
                  ext_pending <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                  brk_pending <= 1'b1;
                end else begin
                  if (shift_reg == JUMP_SCANCODE && !ext_pending)
                    jump_key <= ~brk_pending;
                  ext_pending <= 1'b0;
                  brk_pending <= 1'b0;
                end
              end else begin
                frame_error <= 1'b1;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Data path capture: LSB-first shift register and parity bit, no reset needed
  always_ff @(posedge proc_clk) begin
    if (fall && !timeout_hit) begin
      if (state == DATA)   shift_reg  <= {data_bit, shift_reg[7:1]};
      if (state == PARITY) parity_bit <= data_bit;
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: table of scripted frames, hand-written timeout
// and reset sequences, then random frames against a prefix-queue key model.
`timescale 1ns/1ps
module tb_ps2_key_receiver;

  localparam int TO = 200;   // watchdog length used for this bench
  localparam int H  = 10;    // ps2_clk half period in proc_clk cycles

  logic       proc_clk = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       jump_key;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;

  ps2_key_receiver #(.JUMP_SCANCODE(8'h29), .TIMEOUT_CYCLES(TO)) dut (
    .proc_clk   (proc_clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .jump_key   (jump_key),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_error(frame_error)
  );

  always #5 proc_clk = ~proc_clk;

  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   cyc      = 0;
  int   nvalid, nerr, ev_cyc;
  int   stop_cyc, last_fall_cyc;
  int   overlap_cnt = 0;
  int   glitch_cnt  = 0;
  logic ign_glitch  = 1'b1;
  logic jump_prev   = 1'b0;
  logic [7:0] got_code;
  logic       got_jump;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_valid;
    logic [7:0] exp_code;
    logic       exp_jump;
  } vec_t;

  vec_t vecs[20];

  // reference model state
  logic [7:0] pre_q[$];
  logic       m_jump;
  logic [7:0] m_code;

  always @(posedge proc_clk) cyc <= cyc + 1;

  always @(negedge proc_clk) begin
    if (scan_valid) begin
      nvalid   = nvalid + 1;
      got_code = scan_code;
      got_jump = jump_key;
    end
    if (frame_error) nerr = nerr + 1;
    if ((scan_valid || frame_error) && ev_cyc < 0) ev_cyc = cyc;
    if (scan_valid && frame_error) overlap_cnt = overlap_cnt + 1;
    if (!ign_glitch && (jump_key != jump_prev) && !scan_valid) glitch_cnt = glitch_cnt + 1;
    jump_prev = jump_key;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                           input logic bad_stop);
    logic p;
    p = ~(^d) ^ bad_par;
    return {~bad_stop, p, d, 1'b0};
  endfunction

  task automatic clear_events();
    nvalid = 0;
    nerr   = 0;
    ev_cyc = -1;
  endtask

  task automatic drive_bits(input logic [10:0] fr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge proc_clk);
      ps2_data = fr[i];
      repeat (H) @(negedge proc_clk);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (i == 10) stop_cyc = cyc;
      repeat (H) @(negedge proc_clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic bad_par,
                           input logic bad_stop, input logic exp_valid,
                           input logic [7:0] exp_code, input logic exp_jump);
    @(negedge proc_clk);
    clear_events();
    drive_bits(mk_frame(d, bad_par, bad_stop), 0, 10);
    repeat (20) @(negedge proc_clk);
    check({name, " valid_count"}, 32'(nvalid), 32'(exp_valid));
    check({name, " error_count"}, 32'(nerr), 32'(!exp_valid));
    check({name, " scan_code"}, 32'(scan_code), 32'(exp_code));
    check({name, " jump_key"}, 32'(jump_key), 32'(exp_jump));
    check({name, " latency"}, 32'(ev_cyc - stop_cyc), 32'd3);
    if (exp_valid) check({name, " jump_at_valid"}, 32'(got_jump), 32'(exp_jump));
  endtask

  // Reference: prefixes gather in a queue; a terminal byte is judged by what preceded it
  task automatic model_byte(input logic [7:0] b, input logic good);
    logic has_e0, has_f0;
    if (!good) begin
      pre_q.delete();
    end else begin
      m_code = b;
      if (b == 8'hE0 || b == 8'hF0) begin
        pre_q.push_back(b);
      end else begin
        has_e0 = 1'b0;
        has_f0 = 1'b0;
        foreach (pre_q[k]) begin
          if (pre_q[k] == 8'hE0) has_e0 = 1'b1;
          if (pre_q[k] == 8'hF0) has_f0 = 1'b1;
        end
        if (b == 8'h29 && !has_e0) m_jump = !has_f0;
        pre_q.delete();
      end
    end
  endtask

  initial begin
    vecs[0]  = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b1};
    vecs[2]  = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b0};
    vecs[4]  = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0};
    vecs[7]  = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0};
    vecs[8]  = '{8'h29, 1'b1, 1'b0, 1'b0, 8'h29, 1'b0};
    vecs[9]  = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1};
    vecs[10] = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1};
    vecs[11] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b1};
    vecs[12] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b1};
    vecs[13] = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1};
    vecs[14] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1};
    vecs[15] = '{8'hE0, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b1};
    vecs[16] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b1};
    vecs[17] = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1};
    vecs[18] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b1};
    vecs[19] = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0};

    clear_events();
    repeat (4) @(negedge proc_clk);
    reset_n = 1'b1;
    repeat (4) @(negedge proc_clk);
    check("reset jump_key", 32'(jump_key), 32'd0);
    check("reset scan_code", 32'(scan_code), 32'd0);
    check("reset scan_valid", 32'(scan_valid), 32'd0);
    check("reset frame_error", 32'(frame_error), 32'd0);
    ign_glitch = 1'b0;

    foreach (vecs[i])
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop,
                vecs[i].exp_valid, vecs[i].exp_code, vecs[i].exp_jump);

    // Timeout: start + 4 data bits, then ps2_clk idles high
    @(negedge proc_clk);
    clear_events();
    drive_bits(mk_frame(8'h29, 1'b0, 1'b0), 0, 4);
    repeat (TO + 40) @(negedge proc_clk);
    check("timeout error_count", 32'(nerr), 32'd1);
    check("timeout valid_count", 32'(nvalid), 32'd0);
    check("timeout latency", 32'(ev_cyc - last_fall_cyc), 32'(TO + 3));
    check("timeout scan_code", 32'(scan_code), 32'h29);
    run_frame("after_timeout", 8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1);

    // Reset in the middle of a frame, after data bit 5
    @(negedge proc_clk);
    drive_bits(mk_frame(8'h29, 1'b0, 1'b0), 0, 6);
    @(negedge proc_clk);
    ign_glitch = 1'b1;
    reset_n = 1'b0;
    #1;
    check("midreset jump_key", 32'(jump_key), 32'd0);
    check("midreset scan_code", 32'(scan_code), 32'd0);
    check("midreset scan_valid", 32'(scan_valid), 32'd0);
    check("midreset frame_error", 32'(frame_error), 32'd0);
    repeat (5) @(negedge proc_clk);
    clear_events();
    reset_n = 1'b1;
    @(negedge proc_clk);
    ign_glitch = 1'b0;
    drive_bits(mk_frame(8'h29, 1'b0, 1'b0), 7, 10);
    repeat (TO + 50) @(negedge proc_clk);
    check("remainder valid_count", 32'(nvalid), 32'd0);
    check("remainder jump_key", 32'(jump_key), 32'd0);
    run_frame("after_reset", 8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1);

    // Random frames against the reference model
    m_jump = 1'b1;
    m_code = 8'h29;
    pre_q.delete();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int         sel, flt;
      logic       bp, bs;
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1:    b = 8'h29;
        2:       b = 8'hF0;
        3:       b = 8'hE0;
        4:       b = 8'h1C;
        default: b = 8'($urandom);
      endcase
      flt = $urandom_range(0, 7);
      bp  = (flt == 0);
      bs  = (flt == 1);
      model_byte(b, !(bp || bs));
      run_frame($sformatf("rnd%0d_%02h", n, b), b, bp, bs, !(bp || bs), m_code, m_jump);
    end

    check("valid_error_overlap", 32'(overlap_cnt), 32'd0);
    check("jump_glitches", 32'(glitch_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
